// File: rtl/gated_clock.sv
// rtl/gated_clock.sv - glitch-free burst clock gate with pulse counter
module gated_clock #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   bypass,
  output logic                   clock_output,
  output logic                   gate_open,
  output logic [COUNT_WIDTH-1:0] pulse_count
);

  logic                   en_l;
  logic                   gate_req;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  assign gate_req = enable | bypass;

  // Gate latch: transparent in the low phase, holds through the high phase, reset forces it closed.
  always_latch begin
    if (reset) begin
      en_l <= 1'b0;
    end else if (!clock) begin
      en_l <= gate_req;
    end
  end

  // Clock path is a single AND; the latch guarantees en_l is stable while clock is high.
  assign clock_output = clock & en_l;
  assign gate_open    = en_l;

  // Count next-state: advance while the gate is open, clear once it is closed.
  always_comb begin
    count_d = '0;
    if (en_l) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register shares the rising edge with the emitted pulse it counts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign pulse_count = count_q;

endmodule

// File: tb/tb_gated_clock.sv
// tb/tb_gated_clock.sv - directed self-checking bench for gated_clock
`timescale 1ns/1ps
module tb_gated_clock;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       bypass;
  logic       clock_output;
  logic       gate_open;
  logic [7:0] pulse_count;

  int  total;
  int  bad;
  int  edges;
  real t_rise;
  real min_w;

  gated_clock #(.COUNT_WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .bypass       (bypass),
    .clock_output (clock_output),
    .gate_open    (gate_open),
    .pulse_count  (pulse_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock_output) begin
    edges  = edges + 1;
    t_rise = $realtime;
  end

  always @(negedge clock_output) begin
    if (($realtime - t_rise) < min_w) min_w = $realtime - t_rise;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    edges = 0;
    min_w = 1.0e9;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    edges  = 0;
    t_rise = 0.0;
    min_w  = 1.0e9;
    reset  = 1'b1;
    enable = 1'b1;
    bypass = 1'b1;

    // Reset overrides enable and bypass in both phases
    repeat (3) @(posedge clock);
    #1;
    chk("rst_hi_co", clock_output, 0);
    chk("rst_hi_gate", gate_open, 0);
    chk("rst_hi_cnt", pulse_count, 0);
    @(negedge clock); #1;
    chk("rst_lo_gate", gate_open, 0);

    // Release in low phase: gate opens at once, pulse on next rising edge
    #1 reset = 1'b0;
    #1;
    chk("rel_lo_gate", gate_open, 1);
    chk("rel_lo_co", clock_output, 0);
    @(posedge clock); #1;
    chk("rel_first_co", clock_output, 1);
    chk("rel_first_cnt", pulse_count, 1);
    @(negedge clock);
    enable = 1'b0;
    bypass = 1'b0;
    @(posedge clock); #1;
    chk("idle_co", clock_output, 0);
    chk("idle_cnt", pulse_count, 0);

    // Eight-pulse burst
    @(negedge clock);
    clear_stats();
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock); #1;
      chk("burst_cnt", pulse_count, i);
    end
    @(negedge clock);
    enable = 1'b0;
    @(posedge clock); #1;
    chk("burst_end_cnt", pulse_count, 0);
    chk("burst_end_co", clock_output, 0);
    chk("burst_edges", edges, 8);
    chk("burst_full_width", (min_w >= 4.999) ? 1 : 0, 1);

    // Request confined to a high phase is ignored
    clear_stats();
    @(posedge clock);
    #1 enable = 1'b1;
    #2 enable = 1'b0;
    @(negedge clock); #1;
    chk("higlitch_gate", gate_open, 0);
    @(posedge clock); #1;
    chk("higlitch_co", clock_output, 0);
    chk("higlitch_cnt", pulse_count, 0);
    chk("higlitch_edges", edges, 0);

    // Clear during high phase: current pulse completes, next suppressed
    @(negedge clock);
    clear_stats();
    enable = 1'b1;
    @(posedge clock); #1;
    chk("midclr_co_hi", clock_output, 1);
    #1 enable = 1'b0;
    #1;
    chk("midclr_still_hi", clock_output, 1);
    @(negedge clock); #1;
    chk("midclr_co_lo", clock_output, 0);
    @(posedge clock); #1;
    chk("midclr_next_co", clock_output, 0);
    chk("midclr_cnt", pulse_count, 0);
    chk("midclr_edges", edges, 1);
    chk("midclr_full_width", (min_w >= 4.999) ? 1 : 0, 1);

    // Bypass for 300 cycles: counter wraps 255 -> 0, ends at 44
    @(negedge clock);
    clear_stats();
    bypass = 1'b1;
    enable = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clock); #1;
      if (i == 255) chk("byp_cnt_255", pulse_count, 255);
      if (i == 256) chk("byp_cnt_wrap", pulse_count, 0);
    end
    chk("byp_cnt_end", pulse_count, 44);
    chk("byp_co", clock_output, 1);
    chk("byp_edges", edges, 300);
    chk("byp_full_width", (min_w >= 4.999) ? 1 : 0, 1);

    // Reset mid-high-phase truncates the pulse and clears the count
    #1 reset = 1'b1;
    #1;
    chk("midrst_co", clock_output, 0);
    chk("midrst_gate", gate_open, 0);
    chk("midrst_cnt", pulse_count, 0);
    @(negedge clock); #1;
    chk("midrst_lo_gate", gate_open, 0);

    // Release while clock high: gate waits for the falling edge
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("relhi_gate", gate_open, 0);
    chk("relhi_co", clock_output, 0);
    @(negedge clock); #1;
    chk("relhi_lo_gate", gate_open, 1);
    @(posedge clock); #1;
    chk("relhi_next_co", clock_output, 1);
    chk("relhi_next_cnt", pulse_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
